alu_mdu_unit: RTL

ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

---
 rtl/alu_mdu_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu_unit.sv
// Integer ALU with iterative multiply/divide behind a valid/ready handshake.
// Single-cycle ops finish in one cycle; MUL and DIV classes use shift-add / restoring loops.
module alu_mdu_unit #(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SHW       = $clog2(XLEN);
  localparam int MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e              state_q;
  op_e                 op_d, op_q;
  logic [XLEN-1:0]     a_q, y_q, result_q;
  logic [2*XLEN-1:0]   acc_q, x_q;
  logic [SHW-1:0]      cnt_q;
  logic                neg_q, aneg_q, dz_q, ovf_q, illegal_q;

  always_comb begin
    op_d = OP_ILL;
    case (opcode)
      7'b0000011, 7'b0100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: op_d = OP_ADD;
      7'b1100011: op_d = OP_SUB;
      7'b0010011: begin
        case (funct3)
          3'b000: op_d = OP_ADD;
          3'b001: op_d = OP_SLL;
          3'b010: op_d = OP_SLT;
          3'b011: op_d = OP_SLTU;
          3'b100: op_d = OP_XOR;
          3'b101: op_d = funct7[5] ? OP_SRA : OP_SRL;
          3'b110: op_d = OP_OR;
          default: op_d = OP_AND;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: op_d = OP_ADD;
            3'b001: op_d = OP_SLL;
            3'b010: op_d = OP_SLT;
            3'b011: op_d = OP_SLTU;
            3'b100: op_d = OP_XOR;
            3'b101: op_d = OP_SRL;
            3'b110: op_d = OP_OR;
            default: op_d = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      op_d = OP_SUB;
          else if (funct3 == 3'b101) op_d = OP_SRA;
        end else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000: op_d = OP_MUL;
            3'b001: op_d = OP_MULH;
            3'b010: op_d = OP_MULHSU;
            3'b011: op_d = OP_MULHU;
            3'b100: op_d = OP_DIV;
            3'b101: op_d = OP_DIVU;
            3'b110: op_d = OP_REM;
            default: op_d = OP_REMU;
          endcase
        end
      end
      default: op_d = OP_ILL;
    endcase
  end

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_d)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  // Both iterative units work on magnitudes; signs are reapplied at the end.
  logic            is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  assign is_mul = op_d inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_div = op_d inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_sgn  = op_d inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op_d inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg  = a_sgn & op_a[XLEN-1];
  assign b_neg  = b_sgn & op_b[XLEN-1];
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;

  logic [2*XLEN-1:0] mul_acc, mul_prod;
  logic [XLEN-1:0]   mul_res;
  always_comb begin
    mul_acc = acc_q;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
      if (y_q[j]) mul_acc = mul_acc + (x_q << j);
    mul_prod = neg_q ? -mul_acc : mul_acc;
    mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // Restoring step: remainder lives in acc_q, dividend/quotient shifts through x_q.
  logic [XLEN:0]   shifted;
  logic            div_ge, is_quo;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res, spec_res;
  always_comb begin
    shifted  = {acc_q[XLEN-1:0], x_q[XLEN-1]};
    div_ge   = shifted >= {1'b0, y_q};
    rem_nxt  = div_ge ? shifted[XLEN-1:0] - y_q : shifted[XLEN-1:0];
    quo_nxt  = {x_q[XLEN-2:0], div_ge};
    is_quo   = op_q inside {OP_DIV, OP_DIVU};
    div_res  = is_quo ? (neg_q ? -quo_nxt : quo_nxt) : (aneg_q ? -rem_nxt : rem_nxt);
    if (dz_q) spec_res = is_quo ? '1 : a_q;
    else      spec_res = is_quo ? a_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ILL;
      a_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      aneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q      <= op_d;
          a_q       <= op_a;
          y_q       <= b_mag;
          x_q       <= {{XLEN{1'b0}}, a_mag};
          acc_q     <= '0;
          neg_q     <= a_neg ^ b_neg;
          aneg_q    <= a_neg;
          dz_q      <= (op_b == '0);
          ovf_q     <= a_sgn & b_sgn & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
          illegal_q <= (op_d == OP_ILL);
          if (is_mul) begin
            cnt_q   <= SHW'(MUL_STEPS-1);
            state_q <= S_MUL;
          end else if (is_div) begin
            cnt_q   <= SHW'(XLEN-1);
            state_q <= S_DIV;
          end else begin
            result_q <= alu_res;
            state_q  <= S_DONE;
          end
        end
        S_MUL: begin
          acc_q <= mul_acc;
          x_q   <= x_q << MUL_BITS_PER_CYCLE;
          y_q   <= y_q >> MUL_BITS_PER_CYCLE;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= mul_res;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          if (dz_q | ovf_q) begin
            result_q <= spec_res;
            state_q  <= S_DONE;
          end else begin
            acc_q <= {{XLEN{1'b0}}, rem_nxt};
            x_q   <= {{XLEN{1'b0}}, quo_nxt};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              result_q <= div_res;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
endmodule
